// File: rtl/taint_sum_monitor_pkg.sv
// Shared PIFT monitor types: event codes, event record and monitor FSM states.
package pift_pkg;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_RISE = 2'd1,
    EVT_PEAK = 2'd2,
    EVT_FALL = 2'd3
  } pift_evt_e;

  typedef enum logic [1:0] {
    MON_IDLE   = 2'd0,
    MON_ACTIVE = 2'd1,
    MON_QUIET  = 2'd2
  } mon_state_e;

  // Default-configuration widths for consumers that want a fixed event record.
  localparam int unsigned PIFT_TS_W  = 32;
  localparam int unsigned PIFT_TOT_W = 11;

  typedef struct packed {
    pift_evt_e                typ;
    logic [PIFT_TS_W-1:0]     ts;
    logic [PIFT_TOT_W-1:0]    total;
  } pift_evt_t;

  // Saturating increment used for the dropped-event counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/taint_sum_monitor_fifo.sv
// Small synchronous event FIFO; pointers cleared by async reset, storage not reset.
module pift_evt_fifo #(
  parameter int unsigned DATA_W = 45,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              push_ok_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  // Head is masked while empty so the outputs read zero out of reset.
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Event storage write.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/taint_sum_monitor.sv
// Taint-sum monitor: sums taint counts, tracks peak, detects rise/quiet and
// queues timestamped events for the simulation harness.
module taint_sum_monitor
  import pift_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 8,
  parameter int unsigned SUM_W        = 8,
  parameter int unsigned TS_W         = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned QUIET_CYCLES = 16,
  localparam int unsigned TOT_W       = SUM_W + $clog2(NUM_SRC)
) (
  input  logic                     CLK,
  input  logic                     ARST,
  input  logic                     en,
  input  logic [NUM_SRC*SUM_W-1:0] src_sum,
  output logic [TOT_W-1:0]         total,
  output logic [TOT_W-1:0]         peak,
  output logic                     live,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [1:0]               evt_type,
  output logic [TS_W-1:0]          evt_ts,
  output logic [TOT_W-1:0]         evt_total,
  output logic [15:0]              evt_drop_cnt
);

  localparam int unsigned QCNT_W = $clog2(QUIET_CYCLES + 1);
  localparam logic [QCNT_W-1:0] QUIET_LIMIT = QCNT_W'(QUIET_CYCLES);

  typedef struct packed {
    pift_evt_e        typ;
    logic [TS_W-1:0]  ts;
    logic [TOT_W-1:0] total;
  } evt_t;

  mon_state_e        state_q, state_d;
  logic [QCNT_W-1:0] qcnt_q, qcnt_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic [TOT_W-1:0]  peak_q, peak_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [15:0]       drop_q;
  pift_evt_e         evt_kind;
  evt_t              push_evt;
  evt_t              head_evt;
  logic [$bits(evt_t)-1:0] head_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push_ok;
  logic              push_req;

  // Sum of all source slices; unknown slices contribute nothing.
  always_comb begin
    logic [SUM_W-1:0] slice;
    slice   = '0;
    total_d = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      slice = src_sum[i*SUM_W +: SUM_W];
      if (!$isunknown(slice)) total_d = total_d + TOT_W'(slice);
    end
  end

  // Monitor FSM next state, quiet counter, peak tracking and event selection.
  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    peak_d   = peak_q;
    ts_d     = ts_q;
    evt_kind = EVT_NONE;
    if (en) begin
      ts_d = ts_q + 1'b1;
      if (total_q > peak_q) peak_d = total_q;
      unique case (state_q)
        MON_IDLE: begin
          if (total_q != '0) begin
            state_d  = MON_ACTIVE;
            evt_kind = EVT_RISE;
          end
        end
        MON_ACTIVE: begin
          if (total_q == '0) begin
            state_d = MON_QUIET;
            qcnt_d  = QCNT_W'(1);
          end
        end
        MON_QUIET: begin
          if (total_q != '0) begin
            state_d = MON_ACTIVE;
            qcnt_d  = '0;
          end else if (qcnt_q == QUIET_LIMIT) begin
            state_d  = MON_IDLE;
            qcnt_d   = '0;
            evt_kind = EVT_FALL;
          end else begin
            qcnt_d = qcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = MON_IDLE;
          qcnt_d  = '0;
        end
      endcase
      // A new peak only reports when the FSM had nothing to say this cycle.
      if (evt_kind == EVT_NONE && total_q > peak_q) evt_kind = EVT_PEAK;
    end
  end

  // Event record presented to the FIFO.
  always_comb begin
    push_evt.typ   = evt_kind;
    push_evt.ts    = ts_q;
    push_evt.total = total_q;
  end

  assign push_req = (evt_kind != EVT_NONE);

  // Monitor state registers; total is sampled regardless of enable.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= MON_IDLE;
      qcnt_q  <= '0;
      total_q <= '0;
      peak_q  <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      total_q <= total_d;
      peak_q  <= peak_d;
      ts_q    <= ts_d;
    end
  end

  // Count events lost because the FIFO had no room.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      drop_q <= '0;
    end else if (push_req && !push_ok) begin
      drop_q <= sat_inc16(drop_q);
    end
  end

  pift_evt_fifo #(
    .DATA_W ($bits(evt_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .arst_i      (ARST),
    .push_i      (push_req),
    .push_data_i (push_evt),
    .pop_i       (evt_ready),
    .head_o      (head_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .push_ok_o   (push_ok)
  );

  assign head_evt     = evt_t'(head_data);
  assign total        = total_q;
  assign peak         = peak_q;
  assign live         = (state_q != MON_IDLE);
  assign evt_valid    = !fifo_empty;
  assign evt_type     = head_evt.typ;
  assign evt_ts       = head_evt.ts;
  assign evt_total    = head_evt.total;
  assign evt_drop_cnt = drop_q;

  // Full flag is only needed inside the FIFO's push decision.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_taint_sum_monitor.sv
// Scoreboard bench for taint_sum_monitor: stimulus pushes expected events,
// a negedge monitor pops and compares each accepted FIFO head.
module tb_taint_sum_monitor;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned TS_W    = 32;
  localparam int unsigned TOT_W   = 11;

  localparam logic [1:0] T_RISE = 2'd1;
  localparam logic [1:0] T_PEAK = 2'd2;
  localparam logic [1:0] T_FALL = 2'd3;

  logic                     CLK;
  logic                     ARST;
  logic                     en;
  logic [NUM_SRC*SUM_W-1:0] src_sum;
  logic [TOT_W-1:0]         total;
  logic [TOT_W-1:0]         peak;
  logic                     live;
  logic                     evt_valid;
  logic                     evt_ready;
  logic [1:0]               evt_type;
  logic [TS_W-1:0]          evt_ts;
  logic [TOT_W-1:0]         evt_total;
  logic [15:0]              evt_drop_cnt;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] ts;
    logic [31:0] tot;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] tscnt;

  taint_sum_monitor #(
    .NUM_SRC      (NUM_SRC),
    .SUM_W        (SUM_W),
    .TS_W         (TS_W),
    .FIFO_DEPTH   (4),
    .QUIET_CYCLES (16)
  ) dut (
    .CLK          (CLK),
    .ARST         (ARST),
    .en           (en),
    .src_sum      (src_sum),
    .total        (total),
    .peak         (peak),
    .live         (live),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_type     (evt_type),
    .evt_ts       (evt_ts),
    .evt_total    (evt_total),
    .evt_drop_cnt (evt_drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference timestamp: cycles elapsed with en=1 since reset.
  always @(posedge CLK or posedge ARST) begin
    if (ARST) tscnt <= '0;
    else if (en) tscnt <= tscnt + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [7:0] v);
    src_sum[i*8 +: 8] = v;
  endtask

  task automatic push_exp(input logic [1:0] typ, input logic [31:0] ts, input logic [31:0] tot);
    exp_t e;
    e.typ = typ;
    e.ts  = ts;
    e.tot = tot;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted head must match the oldest expected event.
  always @(negedge CLK) begin
    exp_t e;
    if (!ARST && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_evt type=%0d ts=%0d total=%0d", evt_type, evt_ts, evt_total);
      end else begin
        e = exp_q.pop_front();
        chk("evt_type", 32'(evt_type), 32'(e.typ));
        chk("evt_ts", evt_ts, e.ts);
        chk("evt_total", 32'(evt_total), e.tot);
      end
    end
  end

  initial begin
    ARST      = 1'b1;
    en        = 1'b1;
    evt_ready = 1'b1;
    src_sum   = '0;
    tick();
    tick();
    ARST = 1'b0;
    tick();

    // Reset state
    chk("rst_total", 32'(total), 0);
    chk("rst_peak", 32'(peak), 0);
    chk("rst_live", 32'(live), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_drop", 32'(evt_drop_cnt), 0);

    // Rise then peak
    set_slice(0, 8'd3);
    tick();
    chk("rise_total", 32'(total), 3);
    push_exp(T_RISE, tscnt, 3);
    tick();
    chk("rise_live", 32'(live), 1);
    chk("rise_peak", 32'(peak), 3);
    set_slice(1, 8'd5);
    tick();
    chk("peak_total", 32'(total), 8);
    push_exp(T_PEAK, tscnt, 8);
    tick();
    chk("peak_val", 32'(peak), 8);

    // Quiet filter: 10 zero cycles then activity, no FALL
    set_slice(0, 8'd0);
    set_slice(1, 8'd0);
    tick();
    for (int k = 0; k < 9; k++) tick();
    chk("quiet10_live", 32'(live), 1);
    set_slice(0, 8'd1);
    tick();
    tick();
    chk("requal_live", 32'(live), 1);

    // Long quiet: exactly one FALL on the 17th zero-total cycle
    set_slice(0, 8'd0);
    tick();
    push_exp(T_FALL, tscnt + 32'd16, 0);
    for (int k = 0; k < 16; k++) tick();
    chk("fall_edge_live", 32'(live), 1);
    tick();
    chk("fall_live", 32'(live), 0);
    for (int k = 0; k < 4; k++) tick();

    // FIFO full: 6 events with consumer stalled, 2 dropped
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_slice(0, 8'(10 + k));
      tick();
      if (k == 0) push_exp(T_RISE, tscnt, 10);
      else if (k < 4) push_exp(T_PEAK, tscnt, 32'(10 + k));
    end
    tick();
    chk("full_drop", 32'(evt_drop_cnt), 2);
    chk("full_valid", 32'(evt_valid), 1);
    chk("full_head_hold", 32'(evt_total), 10);
    // Full + pop + push in one cycle
    set_slice(0, 8'd16);
    tick();
    push_exp(T_PEAK, tscnt, 16);
    evt_ready = 1'b1;
    tick();
    chk("poppush_drop", 32'(evt_drop_cnt), 2);
    for (int k = 0; k < 6; k++) tick();
    chk("drain_valid", 32'(evt_valid), 0);

    // Unknown slice counts as zero
    set_slice(0, 8'd1);
    set_slice(2, 8'hxx);
    tick();
    chk("x_total", 32'(total), 1);
    // Saturated inputs, event left pending for the reset check
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_slice(i, 8'hFF);
    tick();
    chk("max_total", 32'(total), 2040);
    tick();
    chk("max_peak", 32'(peak), 2040);
    chk("max_evt_type", 32'(evt_type), 2);
    chk("max_evt_total", 32'(evt_total), 2040);

    // Asynchronous reset mid-cycle drops the pending event
    #2;
    ARST = 1'b1;
    #1;
    chk("arst_valid", 32'(evt_valid), 0);
    chk("arst_total", 32'(total), 0);
    chk("arst_peak", 32'(peak), 0);
    chk("arst_live", 32'(live), 0);
    chk("arst_drop", 32'(evt_drop_cnt), 0);
    chk("arst_type", 32'(evt_type), 0);

    // Disabled monitor: total follows input, everything else frozen
    en        = 1'b0;
    evt_ready = 1'b1;
    src_sum   = '0;
    set_slice(0, 8'd5);
    tick();
    ARST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("dis_total", 32'(total), 5);
      chk("dis_peak", 32'(peak), 0);
      chk("dis_live", 32'(live), 0);
      chk("dis_valid", 32'(evt_valid), 0);
    end
    // Re-enable: timestamp was held at 0
    en = 1'b1;
    push_exp(T_RISE, 0, 5);
    tick();
    chk("en_live", 32'(live), 1);
    chk("en_peak", 32'(peak), 5);
    for (int k = 0; k < 4; k++) tick();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
